instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the instruction memory and downstream-feeding the decoder. Owns the architectural fetch PC and drives it combinationally to the instruction memory, which returns the word in the same cycle. Captures {pc, instruction} pairs into a small circular fetch queue and presents them to decode over a valid/ready handshake. Accepts branch/jump redirects that flush the queue, and halts on misaligned redirect targets.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
QUEUE_DEPTH, 2, fetch queue entries; power of two, at least 2

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_pc  output  32  address to instruction memory, equals fetch_pc register
imem_instruction  input  32  word returned combinationally for imem_pc
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  32  redirect target
out_valid  output  1  queue head valid to decode
out_ready  input  1  decode accepts head this cycle
out_pc  output  32  PC of head entry
out_instruction  output  32  instruction of head entry
fetch_fault  output  1  sticky misaligned-target flag
fetch_fault_pc  output  32  offending target address

Behaviour:
- Reset (synchronous, evaluated at the clock edge, overrides everything including a redirect in the same cycle):
  - fetch_pc = RESET_PC; queue count = 0; read and write pointers = 0; state = RUN.
  - out_valid = 0; fetch_fault = 0; fetch_fault_pc = 0.
  - out_pc and out_instruction read the head slot. They are 0 after reset.
- FSM states:
  - RUN: fetch active.
  - HALT: fetch stopped after a misaligned redirect.
- Queue:
  - Circular buffer of QUEUE_DEPTH entries; count ranges 0..QUEUE_DEPTH.
  - out_valid = (count != 0). Head is driven combinationally from the registered slot.
  - pop = out_valid && out_ready.
  - push = (state == RUN) && !redirect_valid && (count < QUEUE_DEPTH || pop). A full queue with a simultaneous pop accepts the push.
  - Push writes {fetch_pc, imem_instruction} at the write pointer, then fetch_pc <= fetch_pc + 4. Addition is modulo 2^32: FFFFFFFC wraps to 00000000.
  - No push means fetch_pc holds, so imem_pc is stable while stalled.
  - Simultaneous push and pop leaves count unchanged.
- Latency: an instruction is enqueued in the cycle its PC is on imem_pc and becomes visible at out_valid the next cycle. Sustained throughput is 1 instruction/cycle while out_ready = 1.
- Redirect (redirect_valid = 1, not reset):
  - Highest priority. Queue flushed (count = 0, pointers = 0); any pop and push that cycle are discarded.
  - Aligned target (redirect_pc[1:0] == 0): fetch_pc <= redirect_pc; state <= RUN; fetch_fault <= 0.
  - Misaligned target: state <= HALT; fetch_fault <= 1; fetch_fault_pc <= redirect_pc; fetch_pc unchanged.
  - Redirect-to-valid latency: out_valid = 0 in the cycle after the redirect; the target instruction appears with out_valid = 1 two cycles after the redirect edge.
  - Back-to-back redirects: the last one wins.
- HALT:
  - No pushes; queue stays empty; out_valid = 0; imem_pc holds.
  - Leaves HALT only via reset or an aligned redirect. A further misaligned redirect updates fetch_fault_pc.
- Decode must not depend on out_pc or out_instruction when out_valid = 0.
- Head entry is stable while out_valid && !out_ready.

Test Plan:
- Reset, out_ready = 1, imem returns data[0] = 32'h2BC00093 at pc 0 -> out_valid rises 1 cycle after reset deasserts with out_pc = 0 / out_instruction = 2BC00093; then out_pc = 4, 8, C on consecutive cycles.
- Backpressure: out_ready = 0 for 5 cycles from reset -> count saturates at 2 (entries pc 0, 4), imem_pc holds 0x8. out_ready = 1 -> out_pc 0, 4, 8 on three consecutive cycles with no bubble.
- Redirect to 0x90 in the cycle out_pc = 0x8 with out_ready = 1 -> next cycle out_valid = 0 and imem_pc = 0x90; following cycle out_pc = 0x90 valid; 0x8 never accepted twice; 0xC never presented.
- Misaligned redirect to 0x92 -> fetch_fault = 1 and fetch_fault_pc = 0x92 next cycle; out_valid stays 0 for 10 cycles with imem_pc constant. Then aligned redirect to 0x78 -> fetch_fault = 0, out_pc = 0x78 valid two cycles later.
- RESET_PC = 32'hFFFFFFF8, out_ready = 1 -> out_pc sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- Reset asserted in the same cycle as redirect_valid to 0x40 with a full queue -> next cycle count = 0, fetch_pc = RESET_PC, fetch_fault = 0; the redirect is ignored.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory, redirect and decode-facing signals of the fetch unit
interface instruction_fetch_unit_if;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic        fetch_fault;
    logic [31:0] fetch_fault_pc;

    modport master (
        output imem_pc,
        input  imem_instruction,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instruction,
        output fetch_fault,
        output fetch_fault_pc
    );

    modport slave (
        input  imem_pc,
        output imem_instruction,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instruction,
        input  fetch_fault,
        input  fetch_fault_pc
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch PC owner with circular {pc, instruction} queue toward decode
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    instruction_fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             fault_q, fault_d;
    logic [31:0]      fault_pc_q, fault_pc_d;
    logic             pop, push;

    logic [31:0] pc_mem_q   [QUEUE_DEPTH];
    logic [31:0] insn_mem_q [QUEUE_DEPTH];

    assign bus.imem_pc         = fetch_pc_q;
    assign bus.out_valid       = (count_q != '0);
    assign bus.out_pc          = pc_mem_q[rd_ptr_q];
    assign bus.out_instruction = insn_mem_q[rd_ptr_q];
    assign bus.fetch_fault     = fault_q;
    assign bus.fetch_fault_pc  = fault_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        pop  = (count_q != '0) && bus.out_ready;
        // A full queue still accepts a push when the head leaves in the same cycle.
        push = (state_q == ST_RUN) && !bus.redirect_valid && ((count_q < DEPTH_C) || pop);

        if (bus.redirect_valid) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            if (bus.redirect_pc[1:0] == 2'b00) begin
                fetch_pc_d = bus.redirect_pc;
                state_d    = ST_RUN;
                fault_d    = 1'b0;
            end else begin
                state_d    = ST_HALT;
                fault_d    = 1'b1;
                fault_pc_d = bus.redirect_pc;
            end
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                pc_mem_q[i]   <= 32'h0;
                insn_mem_q[i] <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
                insn_mem_q[wr_ptr_q] <= bus.imem_instruction;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed and random checks of instruction_fetch_unit against a queue model
module tb_instruction_fetch_unit;
    localparam int          DEPTH     = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit_if ifc ();
    instruction_fetch_unit_if ifc2 ();

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    instruction_fetch_unit #(.RESET_PC(RESET_PC2), .QUEUE_DEPTH(DEPTH)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc2)
    );

    function automatic logic [31:0] imem_f(input logic [31:0] pc);
        if (pc == 32'h0) return 32'h2BC0_0093;
        return (pc * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign ifc.imem_instruction  = imem_f(ifc.imem_pc);
    assign ifc2.imem_instruction = imem_f(ifc2.imem_pc);

    logic [31:0] m_pc [$];
    logic [31:0] m_in [$];
    logic [31:0] m_fpc;
    logic        m_halt;
    logic        m_fault;
    logic [31:0] m_fault_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic do_pop, do_push;
        if (reset) begin
            m_pc.delete(); m_in.delete();
            m_fpc = RESET_PC; m_halt = 1'b0; m_fault = 1'b0; m_fault_pc = 32'h0;
        end else if (ifc.redirect_valid) begin
            m_pc.delete(); m_in.delete();
            if (ifc.redirect_pc[1:0] == 2'b00) begin
                m_fpc = ifc.redirect_pc; m_halt = 1'b0; m_fault = 1'b0;
            end else begin
                m_halt = 1'b1; m_fault = 1'b1; m_fault_pc = ifc.redirect_pc;
            end
        end else begin
            do_pop  = (m_pc.size() != 0) && ifc.out_ready;
            do_push = !m_halt && ((m_pc.size() < DEPTH) || do_pop);
            if (do_pop) begin
                void'(m_pc.pop_front());
                void'(m_in.pop_front());
            end
            if (do_push) begin
                m_pc.push_back(m_fpc);
                m_in.push_back(imem_f(m_fpc));
                m_fpc = m_fpc + 32'd4;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("out_valid", {31'b0, ifc.out_valid}, {31'b0, m_pc.size() != 0});
        if (m_pc.size() != 0) begin
            chk("out_pc", ifc.out_pc, m_pc[0]);
            chk("out_instruction", ifc.out_instruction, m_in[0]);
        end
        chk("imem_pc", ifc.imem_pc, m_fpc);
        chk("fetch_fault", {31'b0, ifc.fetch_fault}, {31'b0, m_fault});
        chk("fetch_fault_pc", ifc.fetch_fault_pc, m_fault_pc);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        reset = 1'b0;
    endtask

    logic [31:0] held_pc;
    int          r;

    initial begin
        reset = 1'b1;
        ifc.redirect_valid  = 1'b0;
        ifc.redirect_pc     = 32'h0;
        ifc.out_ready       = 1'b1;
        ifc2.redirect_valid = 1'b0;
        ifc2.redirect_pc    = 32'h0;
        ifc2.out_ready      = 1'b1;

        // reset state and streaming from RESET_PC on both instances
        do_reset();
        chk("rst_out_valid", {31'b0, ifc.out_valid}, 32'h0);
        chk("rst_out_pc", ifc.out_pc, 32'h0);
        chk("rst_out_instruction", ifc.out_instruction, 32'h0);
        chk("rst_fault", {31'b0, ifc.fetch_fault}, 32'h0);
        chk("rst_fault_pc", ifc.fetch_fault_pc, 32'h0);
        chk("rst_imem_pc", ifc.imem_pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("stream_valid", {31'b0, ifc.out_valid}, 32'h1);
            chk("stream_pc", ifc.out_pc, 32'(i * 4));
            chk("wrap_valid", {31'b0, ifc2.out_valid}, 32'h1);
            chk("wrap_pc", ifc2.out_pc, RESET_PC2 + 32'(i * 4));
        end
        chk("first_insn_seen", imem_f(32'h0), 32'h2BC0_0093);

        // backpressure saturation and bubble-free drain
        do_reset();
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("bp_imem_pc", ifc.imem_pc, 32'h8);
        chk("bp_head_pc", ifc.out_pc, 32'h0);
        ifc.out_ready = 1'b1;
        chk("drain0", ifc.out_pc, 32'h0);
        cycle();
        chk("drain4", ifc.out_pc, 32'h4);
        cycle();
        chk("drain8", ifc.out_pc, 32'h8);

        // aligned redirect while head is accepted
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h90;
        cycle();
        ifc.redirect_valid = 1'b0;
        chk("redir_bubble", {31'b0, ifc.out_valid}, 32'h0);
        chk("redir_imem_pc", ifc.imem_pc, 32'h90);
        cycle();
        chk("redir_valid", {31'b0, ifc.out_valid}, 32'h1);
        chk("redir_pc", ifc.out_pc, 32'h90);

        // misaligned redirect halts, aligned redirect recovers
        held_pc = ifc.imem_pc;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h92;
        cycle();
        ifc.redirect_valid = 1'b0;
        chk("mis_fault", {31'b0, ifc.fetch_fault}, 32'h1);
        chk("mis_fault_pc", ifc.fetch_fault_pc, 32'h92);
        for (int i = 0; i < 10; i++) begin
            chk("halt_valid", {31'b0, ifc.out_valid}, 32'h0);
            chk("halt_imem_pc", ifc.imem_pc, held_pc);
            cycle();
        end
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h78;
        cycle();
        ifc.redirect_valid = 1'b0;
        chk("recover_fault", {31'b0, ifc.fetch_fault}, 32'h0);
        chk("recover_bubble", {31'b0, ifc.out_valid}, 32'h0);
        cycle();
        chk("recover_valid", {31'b0, ifc.out_valid}, 32'h1);
        chk("recover_pc", ifc.out_pc, 32'h78);

        // reset wins over a simultaneous redirect with a full queue
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("full_valid", {31'b0, ifc.out_valid}, 32'h1);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h40;
        do_reset();
        ifc.redirect_valid = 1'b0;
        chk("rr_valid", {31'b0, ifc.out_valid}, 32'h0);
        chk("rr_imem_pc", ifc.imem_pc, RESET_PC);
        chk("rr_fault", {31'b0, ifc.fetch_fault}, 32'h0);
        ifc.out_ready = 1'b1;
        cycle();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            ifc.out_ready      = ($urandom_range(0, 3) != 0);
            reset              = (r < 2);
            ifc.redirect_valid = (r >= 2) && (r < 12);
            ifc.redirect_pc    = $urandom();
            if ($urandom_range(0, 3) != 0) ifc.redirect_pc[1:0] = 2'b00;
            cycle();
        end
        reset = 1'b0;
        ifc.redirect_valid = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
